// File: rtl/vga_tile_raster.sv
// Purpose: VGA raster engine; sync timing, playfield tile fetch, palette lookup with border fill and edge shading.
// Latency: 3 pixel clocks from counter position to aligned r/g/b, syncs, drawing_pixels and frame_start.
// Backpressure: none; free-running pixel stream, tile memory must answer one cycle after the address.
//
// Ports:
//   clk_25_175, reset     pixel clock, asynchronous active-low reset
//   tile_h, tile_v        tile column/row address to the block memory (0 outside the playfield)
//   tile_type             registered memory data, valid the cycle after the address
//   pal_we/addr/data      palette write port, {r,g,b} packed, takes effect on the next edge
//   h_sync, v_sync        sync outputs, active level SYNC_POL
//   r, g, b               colour outputs, CW bits each
//   drawing_pixels        output pixel lies in the active area
//   frame_start           one-cycle pulse on output pixel (0,0)
module vga_tile_raster #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_POL   = 0,
    parameter int CW         = 4,
    parameter int TILE_SHIFT = 4,
    parameter int ORG_X      = 240,
    parameter int ORG_Y      = 80,
    parameter int COLS       = 10,
    parameter int ROWS       = 20,
    parameter logic [3*CW-1:0] BORDER_RGB = 12'h333
) (
    input  logic              clk_25_175,
    input  logic              reset,
    output logic [4:0]        tile_h,
    output logic [4:0]        tile_v,
    input  logic [2:0]        tile_type,
    input  logic              pal_we,
    input  logic [2:0]        pal_addr,
    input  logic [3*CW-1:0]   pal_data,
    output logic              h_sync,
    output logic              v_sync,
    output logic [CW-1:0]     r,
    output logic [CW-1:0]     g,
    output logic [CW-1:0]     b,
    output logic              drawing_pixels,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam int PF_W      = COLS << TILE_SHIFT;
    localparam int PF_H      = ROWS << TILE_SHIFT;
    localparam int TILE_MASK = (1 << TILE_SHIFT) - 1;
    localparam logic SYNC_LVL = (SYNC_POL != 0);

    function automatic logic [3*CW-1:0] pal_init(input logic [2:0] idx);
        return {{CW{idx[2]}}, {CW{idx[1]}}, {CW{idx[0]}}};
    endfunction

    // ---------------- stage 0: raster counters ----------------
    logic [HW-1:0] hc;
    logic [VW-1:0] vc;

    always_ff @(posedge clk_25_175 or negedge reset) begin
        if (!reset) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == H_LAST) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
        end else begin
            hc <= hc + 1'b1;
        end
    end

    // Position decode done in int so the origin subtraction never wraps:
    // the playfield test is made on the signed difference.
    logic       act0, pf0, edg0, hs0, vs0, fs0;
    logic [4:0] tile_h_nxt, tile_v_nxt;
    int         hc_i, vc_i, x_i, y_i;

    always_comb begin
        hc_i = int'(hc);
        vc_i = int'(vc);
        x_i  = hc_i - ORG_X;
        y_i  = vc_i - ORG_Y;
        act0 = (hc_i < H_ACTIVE) && (vc_i < V_ACTIVE);
        hs0  = (hc_i >= H_ACTIVE + H_FP) && (hc_i < H_ACTIVE + H_FP + H_SYNC);
        vs0  = (vc_i >= V_ACTIVE + V_FP) && (vc_i < V_ACTIVE + V_FP + V_SYNC);
        fs0  = (hc == '0) && (vc == '0);
        pf0  = (hc_i >= ORG_X) && (x_i < PF_W) && (vc_i >= ORG_Y) && (y_i < PF_H);
        edg0 = ((x_i & TILE_MASK) == 0) || ((y_i & TILE_MASK) == 0);
        tile_h_nxt = '0;
        tile_v_nxt = '0;
        if (pf0) begin
            tile_h_nxt = 5'(x_i >> TILE_SHIFT);
            tile_v_nxt = 5'(y_i >> TILE_SHIFT);
        end
    end

    // ---------------- stage 1: memory address ----------------
    logic act1, pf1, edg1, hs1, vs1, fs1;

    always_ff @(posedge clk_25_175 or negedge reset) begin
        if (!reset) begin
            tile_h <= '0;
            tile_v <= '0;
            act1   <= 1'b0;
            pf1    <= 1'b0;
            edg1   <= 1'b0;
            hs1    <= 1'b0;
            vs1    <= 1'b0;
            fs1    <= 1'b0;
        end else begin
            tile_h <= tile_h_nxt;
            tile_v <= tile_v_nxt;
            act1   <= act0;
            pf1    <= pf0;
            edg1   <= edg0 && pf0;
            hs1    <= hs0;
            vs1    <= vs0;
            fs1    <= fs0;
        end
    end

    // ---------------- stage 2: tile_type valid, palette lookup ----------------
    logic act2, pf2, edg2, hs2, vs2, fs2;

    always_ff @(posedge clk_25_175 or negedge reset) begin
        if (!reset) begin
            act2 <= 1'b0;
            pf2  <= 1'b0;
            edg2 <= 1'b0;
            hs2  <= 1'b0;
            vs2  <= 1'b0;
            fs2  <= 1'b0;
        end else begin
            act2 <= act1;
            pf2  <= pf1;
            edg2 <= edg1;
            hs2  <= hs1;
            vs2  <= vs1;
            fs2  <= fs1;
        end
    end

    // Palette: the lookup below reads the array combinationally, so a write
    // in the same cycle is only visible to later lookups.
    logic [3*CW-1:0] pal [8];

    always_ff @(posedge clk_25_175 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                pal[i] <= pal_init(3'(i));
            end
        end else if (pal_we) begin
            pal[pal_addr] <= pal_data;
        end
    end

    logic [3*CW-1:0] pix, shaded, rgb_nxt;

    always_comb begin
        pix    = pal[tile_type];
        shaded = {pix[3*CW-1 -: CW] >> 1, pix[2*CW-1 -: CW] >> 1, pix[CW-1:0] >> 1};
        rgb_nxt = '0;
        if (act2) begin
            if (!pf2) begin
                rgb_nxt = BORDER_RGB;
            end else if (tile_type == 3'd0) begin
                rgb_nxt = pal[0];
            end else if (edg2) begin
                rgb_nxt = shaded;
            end else begin
                rgb_nxt = pix;
            end
        end
    end

    // ---------------- stage 3: aligned outputs ----------------
    always_ff @(posedge clk_25_175 or negedge reset) begin
        if (!reset) begin
            r              <= '0;
            g              <= '0;
            b              <= '0;
            h_sync         <= ~SYNC_LVL;
            v_sync         <= ~SYNC_LVL;
            drawing_pixels <= 1'b0;
            frame_start    <= 1'b0;
        end else begin
            {r, g, b}      <= rgb_nxt;
            h_sync         <= hs2 ? SYNC_LVL : ~SYNC_LVL;
            v_sync         <= vs2 ? SYNC_LVL : ~SYNC_LVL;
            drawing_pixels <= act2;
            frame_start    <= fs2;
        end
    end

endmodule

// File: tb/tb_vga_tile_raster.sv
// Purpose: directed bench for vga_tile_raster on two reduced-timing instances (CW=4 and CW=8 sweep).
// Latency: output pixel p appears after edge p+3 counted from reset release.
// Backpressure: none; the bench models the registered tile memory.
module tb_vga_tile_raster;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // instance 0: 80x56 total, 64x48 active, 4-px tiles, 12-bit colour
    logic [4:0]  tile_h0, tile_v0;
    logic [2:0]  mem0;
    logic        pal_we0;
    logic [2:0]  pal_addr0;
    logic [11:0] pal_data0;
    logic        hs0, vs0, dp0, fs0;
    logic [3:0]  r0, g0, b0;

    // instance 1: 120x56 total, 104x48 active, 8-px tiles, 12 columns, 24-bit colour
    logic [4:0]  tile_h1, tile_v1;
    logic [2:0]  mem1;
    logic        pal_we1 = 1'b0;
    logic [2:0]  pal_addr1 = 3'd0;
    logic [23:0] pal_data1 = 24'd0;
    logic        hs1, vs1, dp1, fs1;
    logic [7:0]  r1, g1, b1;

    vga_tile_raster #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .SYNC_POL(0), .CW(4), .TILE_SHIFT(2),
        .ORG_X(16), .ORG_Y(8), .COLS(10), .ROWS(8),
        .BORDER_RGB(12'h333)
    ) u0 (
        .clk_25_175(clk), .reset(rst_n),
        .tile_h(tile_h0), .tile_v(tile_v0), .tile_type(mem0),
        .pal_we(pal_we0), .pal_addr(pal_addr0), .pal_data(pal_data0),
        .h_sync(hs0), .v_sync(vs0), .r(r0), .g(g0), .b(b0),
        .drawing_pixels(dp0), .frame_start(fs0)
    );

    vga_tile_raster #(
        .H_ACTIVE(104), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .SYNC_POL(0), .CW(8), .TILE_SHIFT(3),
        .ORG_X(4), .ORG_Y(8), .COLS(12), .ROWS(4),
        .BORDER_RGB(24'h333333)
    ) u1 (
        .clk_25_175(clk), .reset(rst_n),
        .tile_h(tile_h1), .tile_v(tile_v1), .tile_type(mem1),
        .pal_we(pal_we1), .pal_addr(pal_addr1), .pal_data(pal_data1),
        .h_sync(hs1), .v_sync(vs1), .r(r1), .g(g1), .b(b1),
        .drawing_pixels(dp1), .frame_start(fs1)
    );

    // registered tile memory: type = (tile_h + tile_v) mod 8
    always @(posedge clk) begin
        mem0 <= 3'(tile_h0 + tile_v0);
        mem1 <= 3'(tile_h1 + tile_v1);
    end

    int n_cmp = 0;
    int n_bad = 0;
    int edges = 0;
    int hs_lo0 = 0, vs_lo0 = 0, dp_cnt0 = 0, np0 = 0;
    int hs_lo1 = 0, dp_cnt1 = 0, np1 = 0;
    int pulse0 [4];
    int pulse1 [4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock; sample 1 ns after the edge and accumulate frame statistics
    task automatic step();
        @(posedge clk);
        #1;
        edges++;
        if (fs0) begin
            if (np0 < 4) pulse0[np0] = edges;
            np0++;
        end
        if (fs1) begin
            if (np1 < 4) pulse1[np1] = edges;
            np1++;
        end
        if (edges >= 3 && edges <= 8962) begin
            if (!hs0) hs_lo0++;
            if (!vs0) vs_lo0++;
            if (dp0)  dp_cnt0++;
        end
        if (edges >= 3 && edges <= 6722) begin
            if (!hs1) hs_lo1++;
            if (dp1)  dp_cnt1++;
        end
        // instance 1 directed pixels (line length 120)
        if (edges == 8*120 + 92 + 1) chk("u1_tile_h_col11", tile_h1, 32'd11);
        if (edges == 8*120 + 92 + 3) chk("u1_edge_92_8", {r1, g1, b1}, 32'h007F7F);
        if (edges == 8*120 + 100 + 3) chk("u1_border_100_8", {r1, g1, b1}, 32'h333333);
        if (edges == 9*120 + 99 + 3) chk("u1_inner_99_9", {r1, g1, b1}, 32'h00FFFF);
    endtask

    // advance until instance-0 output pixel (x,y) of the first frame is visible
    task automatic goto(input int x, input int y);
        int target;
        target = y*80 + x + 3;
        while (edges < target) step();
    endtask

    initial begin
        pal_we0   = 1'b0;
        pal_addr0 = 3'd0;
        pal_data0 = 12'd0;

        #22;
        chk("rst_rgb", {r0, g0, b0}, 32'h0);
        chk("rst_hsync", hs0, 32'h1);
        chk("rst_vsync", vs0, 32'h1);
        chk("rst_fs", fs0, 32'h0);
        chk("rst_tile", {tile_h0, tile_v0}, 32'h0);

        // run into the playfield, then reset in the middle of a line
        @(negedge clk);
        rst_n = 1'b1;
        repeat (1000) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rgb", {r0, g0, b0}, 32'h0);
        chk("mid_rst_sync", {hs0, vs0}, 32'h3);
        chk("mid_rst_dp_fs", {dp0, fs0}, 32'h0);
        chk("mid_rst_tile", {tile_h0, tile_v0}, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        edges = 0;
        step(); chk("fs_edge1", fs0, 32'h0);
                chk("hsync_edge1", hs0, 32'h1);
        step(); chk("fs_edge2", fs0, 32'h0);
        step(); chk("fs_edge3", fs0, 32'h1);
                chk("dp_edge3", dp0, 32'h1);
        step(); chk("fs_edge4", fs0, 32'h0);

        goto(66, 2);  chk("blank_66_2", {r0, g0, b0}, 32'h0);
                      chk("blank_66_2_dp", dp0, 32'h0);
        goto(15, 8);  chk("border_15_8", {r0, g0, b0}, 32'h333);
        goto(16, 8);  chk("pf_16_8_type0", {r0, g0, b0}, 32'h000);
                      chk("pf_16_8_dp", dp0, 32'h1);
        goto(20, 8);  chk("edge_20_8_t1", {r0, g0, b0}, 32'h007);
        goto(56, 8);  chk("border_56_8", {r0, g0, b0}, 32'h333);
        goto(20, 12); chk("edge_20_12_t2", {r0, g0, b0}, 32'h070);
                      chk("tile_addr_22_12", {tile_h0, tile_v0}, {22'd0, 5'd1, 5'd1});
        goto(21, 13); chk("inner_21_13_t2", {r0, g0, b0}, 32'h0F0);

        // palette write in the lookup cycle of pixel (21,17), a type-3 interior pixel
        goto(20, 17);
        pal_we0   = 1'b1;
        pal_addr0 = 3'd3;
        pal_data0 = 12'hF80;
        step();
        pal_we0   = 1'b0;
        chk("pal_same_cycle_old", {r0, g0, b0}, 32'h0FF);
        step();
        chk("pal_new_inner", {r0, g0, b0}, 32'hF80);
        goto(20, 18); chk("pal_new_edge", {r0, g0, b0}, 32'h740);
        goto(60, 20); chk("tile_addr_outside", {tile_h0, tile_v0}, 32'h0);
        goto(16, 40); chk("border_16_40", {r0, g0, b0}, 32'h333);
        goto(63, 47); chk("last_active", {r0, g0, b0, 3'b000, dp0}, 32'h3331);
        goto(10, 50); chk("vblank_10_50", {r0, g0, b0, 3'b000, dp0}, 32'h0);

        while (edges < 8970) step();

        chk("hsync_low_2fr", hs_lo0, 32'd896);
        chk("vsync_low_2fr", vs_lo0, 32'd320);
        chk("drawing_2fr", dp_cnt0, 32'd6144);
        chk("fs_count", np0, 32'd3);
        chk("fs_first", pulse0[0], 32'd3);
        chk("fs_period1", pulse0[1] - pulse0[0], 32'd4480);
        chk("fs_period2", pulse0[2] - pulse0[1], 32'd4480);
        chk("u1_fs_count", np1, 32'd2);
        chk("u1_fs_period", pulse1[1] - pulse1[0], 32'd6720);
        chk("u1_hsync_low", hs_lo1, 32'd448);
        chk("u1_drawing", dp_cnt1, 32'd4992);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
